// File: rtl/mem_bus_initiator.sv
// -----------------------------------------------------------------------------
// mem_bus_initiator
//
// Purpose
//   Requester side of the single-beat VME-style memory bus used by the
//   generated register/memory maps. One command from a local controller
//   (sequencer, debug port) becomes exactly one read or write strobe. The
//   block then waits, with a timeout, for the matching done pulse and returns
//   the outcome on a response channel. Only one transaction is outstanding
//   at a time; there is no pipelining.
//
// Handshake semantics (both channels)
//   A transfer happens on a rising clk_i edge where valid and ready are both
//   1. The producer keeps valid high, with its payload stable, until that
//   edge. Ready may change freely while valid is low. This block never makes
//   cmd_ready_o depend on cmd_valid_i. It holds rsp_valid_o and its payload
//   (rsp_rdata_o, rsp_err_o) constant from the first response cycle through
//   the accepting edge.
//
// Ports
//   clk_i, rst_n         clock; synchronous active-low reset
//   cmd_valid_i/ready_o  command channel; payload cmd_we_i (1 = write),
//                        cmd_addr_i (word address), cmd_wdata_i
//   rsp_valid_o/ready_i  response channel; payload rsp_rdata_o (read data,
//                        0 for writes and timeouts), rsp_err_o (1 = timeout)
//   bus_addr_o           slave Addr (word address, bus bits [19:2])
//   bus_wrdata_o         slave WrData
//   bus_rdmem_o          one-cycle read strobe
//   bus_wrmem_o          one-cycle write strobe
//   bus_rddata_i         slave RdData, captured in the read-done cycle
//   bus_rddone_i         read done pulse
//   bus_wrdone_i         write done pulse
//   dbg_state_o          current FSM state, for checkers and debug
//
// Timing (command accepted on the edge closing cycle N)
//   strobe in cycle N+1; done in cycle N+1+k  -> rsp_valid_o in N+2+k
//   no done                                   -> rsp_valid_o in N+1+g_timeout
// -----------------------------------------------------------------------------
module mem_bus_initiator #(
  parameter int g_addr_width = 18,
  parameter int g_data_width = 32,
  parameter int g_timeout    = 255   // must be >= 1
) (
  input  logic                    clk_i,
  input  logic                    rst_n,
  // command channel
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic                    cmd_we_i,
  input  logic [g_addr_width-1:0] cmd_addr_i,
  input  logic [g_data_width-1:0] cmd_wdata_i,
  // response channel
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [g_data_width-1:0] rsp_rdata_o,
  output logic                    rsp_err_o,
  // memory bus
  output logic [g_addr_width-1:0] bus_addr_o,
  output logic [g_data_width-1:0] bus_wrdata_o,
  output logic                    bus_rdmem_o,
  output logic                    bus_wrmem_o,
  input  logic [g_data_width-1:0] bus_rddata_i,
  input  logic                    bus_rddone_i,
  input  logic                    bus_wrdone_i,
  // debug
  output logic [1:0]              dbg_state_o
);

  // The counter only has to reach g_timeout-1. It is cleared in STROBE, so
  // it never wraps.
  localparam int c_cnt_width = $clog2(g_timeout + 1);
  localparam logic [c_cnt_width-1:0] c_cnt_last = c_cnt_width'(g_timeout - 1);

  localparam logic [1:0] s_idle   = 2'd0;
  localparam logic [1:0] s_strobe = 2'd1;
  localparam logic [1:0] s_wait   = 2'd2;
  localparam logic [1:0] s_resp   = 2'd3;

  logic [1:0]              state_q, state_d;
  logic                    we_q,    we_d;
  logic [g_addr_width-1:0] addr_q,  addr_d;
  logic [g_data_width-1:0] wdata_q, wdata_d;
  logic [c_cnt_width-1:0]  cnt_q,   cnt_d;
  logic [g_data_width-1:0] rdata_q, rdata_d;
  logic                    err_q,   err_d;

  logic                    done_match;
  logic [c_cnt_width-1:0]  cnt_inc;

  // Only the done pulse that matches the latched direction counts. The other
  // pulse is ignored, whatever state the FSM is in.
  assign done_match = we_q ? bus_wrdone_i : bus_rddone_i;
  assign cnt_inc    = cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;

    case (state_q)
      s_idle: begin
        // Done pulses seen here are late or spurious. This state never
        // looks at them.
        if (cmd_valid_i) begin
          we_d    = cmd_we_i;
          addr_d  = cmd_addr_i;
          wdata_d = cmd_wdata_i;
          rdata_d = '0;
          err_d   = 1'b0;
          state_d = s_strobe;
        end
      end

      s_strobe: begin
        cnt_d = '0;
        // Sampling done in the strobe cycle itself supports slaves that
        // answer with zero latency.
        if (done_match) begin
          rdata_d = we_q ? '0 : bus_rddata_i;
          err_d   = 1'b0;
          state_d = s_resp;
        end else if (g_timeout == 1) begin
          // A budget of one cycle ends with the strobe itself.
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = s_resp;
        end else begin
          state_d = s_wait;
        end
      end

      s_wait: begin
        cnt_d = cnt_inc;
        // The done test comes first, so a done in the last allowed cycle
        // beats the timeout.
        if (done_match) begin
          rdata_d = we_q ? '0 : bus_rddata_i;
          err_d   = 1'b0;
          state_d = s_resp;
        end else if (cnt_inc == c_cnt_last) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = s_resp;
        end
      end

      s_resp: begin
        // rdata/err are not touched here, so a stray done cannot change a
        // response that is waiting to be taken. Going to IDLE, and not
        // straight to a new accept, gives the one-cycle gap after each
        // response.
        if (rsp_ready_i) begin
          state_d = s_idle;
        end
      end

      default: begin
        state_d = s_idle;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      // Reset aborts any transaction silently. Strobes drop on this edge,
      // and the return to IDLE drops any pending response.
      state_q <= s_idle;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Every output comes straight from a flop or a state decode, so no input
  // reaches an output combinationally. The one exception is rst_n, which
  // holds ready low during reset.
  assign cmd_ready_o  = (state_q == s_idle) && rst_n;
  assign bus_rdmem_o  = (state_q == s_strobe) && !we_q;
  assign bus_wrmem_o  = (state_q == s_strobe) && we_q;
  assign bus_addr_o   = addr_q;
  assign bus_wrdata_o = wdata_q;
  assign rsp_valid_o  = (state_q == s_resp);
  assign rsp_rdata_o  = rdata_q;
  assign rsp_err_o    = err_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_mem_bus_initiator.sv
// -----------------------------------------------------------------------------
// tb_mem_bus_initiator
//
// Bench for mem_bus_initiator, built with g_timeout = 8. Inputs are driven
// 1 time unit after the rising edge. Outputs are sampled 1 time unit later.
// Each transaction is scored against a response model. The model works from
// the done latency k alone: if 0 <= k < g_timeout the result arrives k+2
// cycles after accept, otherwise a timeout arrives g_timeout+1 cycles after
// accept.
// -----------------------------------------------------------------------------
module tb_mem_bus_initiator;

  localparam int AW = 18;
  localparam int DW = 32;
  localparam int T  = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          cmd_valid, cmd_ready, cmd_we;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wrdata, bus_rddata;
  logic          bus_rdmem, bus_wrmem, bus_rddone, bus_wrdone;
  logic [1:0]    dbg_state;
  logic [1:0]    idle_code;

  mem_bus_initiator #(
    .g_addr_width(AW),
    .g_data_width(DW),
    .g_timeout   (T)
  ) dut (
    .clk_i       (clk),
    .rst_n       (rst_n),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_we_i    (cmd_we),
    .cmd_addr_i  (cmd_addr),
    .cmd_wdata_i (cmd_wdata),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_rdata_o (rsp_rdata),
    .rsp_err_o   (rsp_err),
    .bus_addr_o  (bus_addr),
    .bus_wrdata_o(bus_wrdata),
    .bus_rdmem_o (bus_rdmem),
    .bus_wrmem_o (bus_wrmem),
    .bus_rddata_i(bus_rddata),
    .bus_rddone_i(bus_rddone),
    .bus_wrdone_i(bus_wrdone),
    .dbg_state_o (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [DW:0] exp_q[$];   // {err, rdata} in command order

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int model_lat(input int k);
    if (k >= 0 && k < T) return 2 + k;
    return 1 + T;
  endfunction

  function automatic logic [DW:0] model_rsp(input logic we, input int k, input logic [DW-1:0] rdval);
    if (k >= 0 && k < T) return {1'b0, (we ? {DW{1'b0}} : rdval)};
    return {1'b1, {DW{1'b0}}};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction. k is the done latency after the strobe: -1 means
  // the slave stays silent. wrong_at is the cycle of a non-matching done,
  // or -1 for none. stall is the number of cycles rsp_ready stays low.
  // hold keeps cmd_valid high after accept.
  task automatic run_txn(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                         input int k, input logic [DW-1:0] rdval, input int wrong_at,
                         input int stall, input logic hold,
                         input logic exp_err, input logic [DW-1:0] exp_rdata, input int exp_lat);
    logic [DW:0] exp_rsp;
    cmd_we    = we;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    cmd_valid = 1'b1;
    exp_q.push_back({exp_err, exp_rdata});
    #1;
    check("accept_ready", 64'(cmd_ready), 64'(1));
    tick();
    cmd_valid = hold;
    for (int c = 1; c <= exp_lat; c++) begin
      bus_rddone = !we && (c == 1 + k);
      bus_wrdone = we && (c == 1 + k);
      if (c == wrong_at) begin
        if (we) bus_rddone = 1'b1;
        else    bus_wrdone = 1'b1;
      end
      bus_rddata = (c == 1 + k) ? rdval : DW'($urandom);
      #1;
      check("rdmem", 64'(bus_rdmem), 64'((c == 1) && !we));
      check("wrmem", 64'(bus_wrmem), 64'((c == 1) && we));
      check("cmd_ready_busy", 64'(cmd_ready), 64'(0));
      check("rsp_valid_timing", 64'(rsp_valid), 64'(c == exp_lat));
      if (c < exp_lat) begin
        check("bus_addr", 64'(bus_addr), 64'(addr));
        check("bus_wrdata", 64'(bus_wrdata), 64'(wdata));
        tick();
      end
    end
    exp_rsp = exp_q.pop_front();
    for (int s = 0; s <= stall; s++) begin
      if (s > 0) begin
        // stray done pulses while a response is pending
        bus_rddone = 1'($urandom_range(0, 1));
        bus_wrdone = 1'($urandom_range(0, 1));
        bus_rddata = DW'($urandom);
        #1;
      end
      rsp_ready = (s == stall);
      check("rsp_valid_hold", 64'(rsp_valid), 64'(1));
      check("rsp_payload", 64'({rsp_err, rsp_rdata}), 64'(exp_rsp));
      check("cmd_ready_resp", 64'(cmd_ready), 64'(0));
      tick();
    end
    rsp_ready  = 1'b0;
    bus_rddone = 1'b0;
    bus_wrdone = 1'b0;
    #1;
    check("rsp_valid_drop", 64'(rsp_valid), 64'(0));
    check("cmd_ready_idle", 64'(cmd_ready), 64'(1));
    check("dbg_state_idle", 64'(dbg_state), 64'(idle_code));
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            k;
    logic [DW-1:0] rdval;
    int            wrong_at;
    logic          exp_err;
    logic [DW-1:0] exp_rdata;
    int            exp_lat;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic          r_we;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata, r_rdval;
    logic [DW:0]   r_exp;
    int            r_k, r_kk, r_wrong;

    // write, wrdone 1 cycle after strobe
    vecs[0] = '{we:1'b1, addr:18'h00123, wdata:32'hCAFEF00D, k:1, rdval:32'hDEADBEEF, wrong_at:-1,
                exp_err:1'b0, exp_rdata:32'h0, exp_lat:3};
    // read, rddone 2 cycles after strobe
    vecs[1] = '{we:1'b0, addr:18'h00010, wdata:32'h0, k:2, rdval:32'h00001234, wrong_at:-1,
                exp_err:1'b0, exp_rdata:32'h00001234, exp_lat:4};
    // read, silent slave -> timeout
    vecs[2] = '{we:1'b0, addr:18'h3FFFF, wdata:32'h0, k:-1, rdval:32'h0, wrong_at:-1,
                exp_err:1'b1, exp_rdata:32'h0, exp_lat:9};
    // read, wrdone ignored, rddone in the last wait cycle wins over timeout
    vecs[3] = '{we:1'b0, addr:18'h00200, wdata:32'h0, k:7, rdval:32'hA5A55A5A, wrong_at:3,
                exp_err:1'b0, exp_rdata:32'hA5A55A5A, exp_lat:9};
    // zero-latency write
    vecs[4] = '{we:1'b1, addr:18'h00000, wdata:32'hFFFFFFFF, k:0, rdval:32'h11111111, wrong_at:-1,
                exp_err:1'b0, exp_rdata:32'h0, exp_lat:2};
    // zero-latency read
    vecs[5] = '{we:1'b0, addr:18'h2AAAA, wdata:32'h0, k:0, rdval:32'h13579BDF, wrong_at:-1,
                exp_err:1'b0, exp_rdata:32'h13579BDF, exp_lat:2};
    // write whose done arrives one cycle too late (in RESP)
    vecs[6] = '{we:1'b1, addr:18'h15555, wdata:32'h0BADC0DE, k:8, rdval:32'h0, wrong_at:-1,
                exp_err:1'b1, exp_rdata:32'h0, exp_lat:9};
    // write that only ever sees rddone -> timeout
    vecs[7] = '{we:1'b1, addr:18'h00042, wdata:32'h12345678, k:-1, rdval:32'h0, wrong_at:2,
                exp_err:1'b1, exp_rdata:32'h0, exp_lat:9};

    // ---------------- reset ----------------
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0; bus_rddata = '0; bus_rddone = 1'b0; bus_wrdone = 1'b0;
    repeat (3) tick();
    #1;
    check("rst_cmd_ready", 64'(cmd_ready), 64'(0));
    check("rst_rdmem", 64'(bus_rdmem), 64'(0));
    check("rst_wrmem", 64'(bus_wrmem), 64'(0));
    check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("rst_rsp_err", 64'(rsp_err), 64'(0));
    check("rst_rsp_rdata", 64'(rsp_rdata), 64'(0));
    check("rst_bus_addr", 64'(bus_addr), 64'(0));
    check("rst_bus_wrdata", 64'(bus_wrdata), 64'(0));
    rst_n = 1'b1;
    tick();
    #1;
    check("post_rst_ready", 64'(cmd_ready), 64'(1));
    idle_code = dbg_state;

    // ---------------- table-driven vectors ----------------
    for (int i = 0; i < 8; i++) begin
      run_txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].k, vecs[i].rdval,
              vecs[i].wrong_at, 0, 1'b0, vecs[i].exp_err, vecs[i].exp_rdata, vecs[i].exp_lat);
    end

    // ---------------- timeout, then a late rddone in IDLE ----------------
    run_txn(vecs[2].we, vecs[2].addr, vecs[2].wdata, vecs[2].k, vecs[2].rdval,
            -1, 0, 1'b0, vecs[2].exp_err, vecs[2].exp_rdata, vecs[2].exp_lat);
    bus_rddone = 1'b1;
    bus_rddata = 32'hFEEDFACE;
    tick();
    bus_rddone = 1'b0;
    #1;
    check("idle_done_no_rsp", 64'(rsp_valid), 64'(0));
    check("idle_done_ready", 64'(cmd_ready), 64'(1));
    run_txn(1'b0, 18'h00777, 32'h0, 1, 32'h0F0F0F0F, -1, 0, 1'b0, 1'b0, 32'h0F0F0F0F, 3);

    // ---------------- backpressure with cmd_valid held high ----------------
    run_txn(1'b1, 18'h01234, 32'h55AA55AA, 2, 32'h0, -1, 3, 1'b1, 1'b0, 32'h0, 4);
    run_txn(1'b1, 18'h01234, 32'h55AA55AA, 0, 32'h0, -1, 0, 1'b0, 1'b0, 32'h0, 2);

    // ---------------- reset in the middle of WAIT ----------------
    cmd_we = 1'b0; cmd_addr = 18'h0ABCD; cmd_wdata = 32'h0; cmd_valid = 1'b1;
    #1;
    check("mid_rst_accept", 64'(cmd_ready), 64'(1));
    tick();
    cmd_valid = 1'b0;
    #1;
    check("mid_rst_strobe", 64'(bus_rdmem), 64'(1));
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready_low", 64'(cmd_ready), 64'(0));
    tick();
    rst_n = 1'b1;
    #1;
    check("mid_rst_rdmem", 64'(bus_rdmem), 64'(0));
    check("mid_rst_wrmem", 64'(bus_wrmem), 64'(0));
    check("mid_rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("mid_rst_addr", 64'(bus_addr), 64'(0));
    check("mid_rst_ready", 64'(cmd_ready), 64'(1));
    bus_rddone = 1'b1;
    bus_rddata = 32'h77777777;
    tick();
    bus_rddone = 1'b0;
    for (int i = 0; i < T + 2; i++) begin
      #1;
      check("mid_rst_no_rsp", 64'(rsp_valid), 64'(0));
      check("mid_rst_no_strobe", 64'(bus_rdmem | bus_wrmem), 64'(0));
      tick();
    end

    // ---------------- randomized transactions ----------------
    for (int i = 0; i < 40; i++) begin
      r_we    = 1'($urandom_range(0, 1));
      r_addr  = AW'($urandom);
      r_wdata = DW'($urandom);
      r_rdval = DW'($urandom);
      r_kk    = $urandom_range(0, T + 1);
      r_k     = (r_kk == T + 1) ? -1 : r_kk;
      r_wrong = ($urandom_range(0, 3) == 0) ? $urandom_range(1, model_lat(r_k)) : -1;
      r_exp   = model_rsp(r_we, r_k, r_rdval);
      run_txn(r_we, r_addr, r_wdata, r_k, r_rdval, r_wrong, $urandom_range(0, 2), 1'b0,
              r_exp[DW], r_exp[DW-1:0], model_lat(r_k));
    end

    check("scoreboard_empty", 64'(exp_q.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
